// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ byte sources.
// Latency: request sampled at edge k gives o_fStart in cycle k+1; at least 4 cycles per byte plus transmitter time.
// Backpressure: i_fReady low holds off launch; one byte in flight, released on i_fDone or after TIMEOUT_CYC wait cycles.
//
// Ports:
//   i_Clk, i_Rst      clock, asynchronous active-low reset
//   i_Req, i_Data     per-requester level request and byte (requester k at [k*DATA_W +: DATA_W])
//   i_fReady, i_fDone transmitter idle flag and one-cycle completion pulse
//   o_fStart/o_TxData launch pulse and byte to transmitter (byte held until next grant)
//   o_Grant, o_Ack    one-hot requester in service, one-cycle per-requester acknowledge
//   o_fBusy, o_fErr   not-idle flag, one-cycle timeout-abort pulse
//   o_ErrCnt          saturating timeout count
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [N_REQ-1:0]        i_Req,
    input  logic [N_REQ*DATA_W-1:0] i_Data,
    input  logic                    i_fReady,
    input  logic                    i_fDone,
    output logic                    o_fStart,
    output logic [DATA_W-1:0]       o_TxData,
    output logic [N_REQ-1:0]        o_Grant,
    output logic [N_REQ-1:0]        o_Ack,
    output logic                    o_fBusy,
    output logic                    o_fErr,
    output logic [7:0]              o_ErrCnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   last_nxt;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   sel_nxt;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic               pick_vld;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nxt;

    logic               start_nxt;
    logic [DATA_W-1:0]  tx_data_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [N_REQ-1:0]   ack_nxt;
    logic               busy_nxt;
    logic               err_nxt;
    logic [7:0]         err_cnt_nxt;

    // Search starts just after the last served requester. Iterating offsets
    // from farthest to nearest lets the nearest set request win.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % N_REQ);
            if (i_Req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        sel_nxt     = sel;
        timer_nxt   = timer;
        start_nxt   = 1'b0;
        ack_nxt     = '0;
        err_nxt     = 1'b0;
        tx_data_nxt = o_TxData;
        grant_nxt   = o_Grant;
        err_cnt_nxt = o_ErrCnt;

        case (state)
            IDLE: begin
                if (pick_vld && i_fReady) begin
                    state_nxt   = LAUNCH;
                    sel_nxt     = pick;
                    grant_nxt   = ONE_HOT_0 << pick;
                    tx_data_nxt = i_Data[int'(pick)*DATA_W +: DATA_W];
                    start_nxt   = 1'b1;
                end
            end
            LAUNCH: begin
                timer_nxt = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done has priority over a timeout landing on the same cycle.
                if (i_fDone) begin
                    ack_nxt   = o_Grant;
                    grant_nxt = '0;
                    last_nxt  = sel;
                    state_nxt = RELEASE;
                end else if (timer == TMR_LAST) begin
                    // Advance the pointer anyway so a dead source cannot starve the rest.
                    err_nxt   = 1'b1;
                    grant_nxt = '0;
                    last_nxt  = sel;
                    state_nxt = RELEASE;
                    if (o_ErrCnt != 8'hFF) begin
                        err_cnt_nxt = o_ErrCnt + 8'd1;
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            last     <= LAST_RST;
            sel      <= '0;
            timer    <= '0;
            o_fStart <= 1'b0;
            o_TxData <= '0;
            o_Grant  <= '0;
            o_Ack    <= '0;
            o_fBusy  <= 1'b0;
            o_fErr   <= 1'b0;
            o_ErrCnt <= '0;
        end else begin
            last     <= last_nxt;
            sel      <= sel_nxt;
            timer    <= timer_nxt;
            o_fStart <= start_nxt;
            o_TxData <= tx_data_nxt;
            o_Grant  <= grant_nxt;
            o_Ack    <= ack_nxt;
            o_fBusy  <= busy_nxt;
            o_fErr   <= err_nxt;
            o_ErrCnt <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the round-robin/timeout rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            ready;
    logic            done;
    logic            o_fStart;
    logic [DW-1:0]   o_TxData;
    logic [N-1:0]    o_Grant;
    logic [N-1:0]    o_Ack;
    logic            o_fBusy;
    logic            o_fErr;
    logic [7:0]      o_ErrCnt;

    int total = 0;
    int bad   = 0;
    int m_last;
    int m_errcnt;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst_n),
        .i_Req    (req),
        .i_Data   (data),
        .i_fReady (ready),
        .i_fDone  (done),
        .o_fStart (o_fStart),
        .o_TxData (o_TxData),
        .o_Grant  (o_Grant),
        .o_Ack    (o_Ack),
        .o_fBusy  (o_fBusy),
        .o_fErr   (o_fErr),
        .o_ErrCnt (o_ErrCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next requester in rotation order after 'last' that is requesting.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, o_fStart, 0);
        chk({tag, "_txd"},   o_TxData, 0);
        chk({tag, "_grant"}, o_Grant, 0);
        chk({tag, "_ack"},   o_Ack, 0);
        chk({tag, "_busy"},  o_fBusy, 0);
        chk({tag, "_err"},   o_fErr, 0);
        chk({tag, "_cnt"},   o_ErrCnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        rst_n    = 1'b1;
        m_last   = N - 1;
        m_errcnt = 0;
        @(negedge clk);
    endtask

    // Called at an IDLE-cycle negedge with req/data/ready already driven.
    // done_at: WAIT cycle index in which i_fDone is pulsed, or -1 for none (timeout).
    // mutate: in the first WAIT cycle rewrite the granted byte to 0xAA and drop its request.
    task automatic run_byte(input int done_at, input bit mutate, input bit drop,
                            input string tag, output logic [DW-1:0] launched);
        int            sel;
        logic [DW-1:0] b;
        logic [N-1:0]  g;
        bit            done_seen;
        launched = '0;
        sel = rr_pick(req, m_last);
        if (sel < 0) begin
            bad++;
            $display("FAIL %s no request pending", tag);
            return;
        end
        b = data[sel*DW +: DW];
        g = '0;
        g[sel] = 1'b1;

        @(negedge clk);
        launched = o_TxData;
        chk({tag, "_l_start"}, o_fStart, 1);
        chk({tag, "_l_grant"}, o_Grant, g);
        chk({tag, "_l_txd"},   o_TxData, b);
        chk({tag, "_l_busy"},  o_fBusy, 1);
        chk({tag, "_l_ack"},   o_Ack, 0);

        done_seen = 1'b0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk({tag, "_w_start"}, o_fStart, 0);
            chk({tag, "_w_grant"}, o_Grant, g);
            chk({tag, "_w_txd"},   o_TxData, b);
            chk({tag, "_w_ack"},   o_Ack, 0);
            chk({tag, "_w_err"},   o_fErr, 0);
            if (mutate && c == 0) begin
                data[sel*DW +: DW] = 8'hAA;
                req[sel] = 1'b0;
            end
            if (c == done_at) begin
                done = 1'b1;
                done_seen = 1'b1;
                break;
            end
        end

        @(negedge clk);
        done   = 1'b0;
        m_last = sel;
        if (!done_seen) m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        chk({tag, "_r_ack"},   o_Ack, done_seen ? g : '0);
        chk({tag, "_r_err"},   o_fErr, !done_seen);
        chk({tag, "_r_grant"}, o_Grant, 0);
        chk({tag, "_r_busy"},  o_fBusy, 1);
        chk({tag, "_r_cnt"},   o_ErrCnt, m_errcnt);
        chk({tag, "_r_txd"},   o_TxData, b);
        if (done_seen && drop) req[sel] = 1'b0;

        @(negedge clk);
        chk({tag, "_i_busy"}, o_fBusy, 0);
        chk({tag, "_i_ack"},  o_Ack, 0);
        chk({tag, "_i_err"},  o_fErr, 0);
        chk({tag, "_i_txd"},  o_TxData, b);
    endtask

    initial begin
        logic [DW-1:0] lb;
        int            nrdy;
        int            dd;

        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        ready = 1'b1;
        done  = 1'b0;

        // 1: single requester, normal completion
        do_reset();
        req = 4'b0010;
        data[1*DW +: DW] = 8'h41;
        run_byte(5, 1'b0, 1'b1, "t1", lb);
        chk("t1_byte", lb, 8'h41);

        // 2: all four requesting, re-raised after each ack
        do_reset();
        for (int k = 0; k < N; k++) data[k*DW +: DW] = 8'(8'h30 + k);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_byte(k % 3, 1'b0, 1'b1, "t2", lb);
            chk("t2_order", lb, 8'(8'h30 + (k % N)));
            req = 4'b1111;
        end

        // 3: ready low holds launch; stray done in IDLE ignored
        req   = 4'b0001;
        ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_nostart", o_fStart, 0);
            chk("t3_idle", o_fBusy, 0);
            chk("t3_noack", o_Ack, 0);
            done = (c == 5);
        end
        done  = 1'b0;
        ready = 1'b1;
        run_byte(2, 1'b0, 1'b1, "t3", lb);

        // 4: timeout, pending requester served next, then saturation
        do_reset();
        data = 32'h44_33_22_11;
        req  = 4'b1100;
        run_byte(-1, 1'b0, 1'b1, "t4a", lb);
        chk("t4_cnt1", o_ErrCnt, 1);
        run_byte(TO - 1, 1'b0, 1'b1, "t4b", lb);
        chk("t4_req3", lb, 8'h44);
        for (int k = 0; k < 256; k++) run_byte(-1, 1'b0, 1'b1, "t4s", lb);
        chk("t4_sat", o_ErrCnt, 255);

        // 5: async reset in the middle of WAIT_DONE
        req = 4'b0100;
        @(negedge clk);
        chk("t5_grant", o_Grant, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t5_async");
        @(negedge clk);
        rst_n    = 1'b1;
        m_last   = N - 1;
        m_errcnt = 0;
        req      = 4'b0101;
        run_byte(3, 1'b0, 1'b1, "t5", lb);
        chk("t5_first", lb, 8'h11);

        // 6: granted byte frozen while source changes data and drops request
        req = 4'b1000;
        data[3*DW +: DW] = 8'h55;
        run_byte(4, 1'b1, 1'b1, "t6", lb);
        chk("t6_byte", lb, 8'h55);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) data[k*DW +: DW] = 8'($urandom);
            end
            nrdy = $urandom_range(0, 2);
            if (nrdy > 0) begin
                ready = 1'b0;
                for (int c = 0; c < nrdy; c++) begin
                    @(negedge clk);
                    chk("rnd_hold", o_fStart, 0);
                end
                ready = 1'b1;
            end
            dd = $urandom_range(0, TO);
            if (dd == TO) dd = -1;
            run_byte(dd, 1'b0, 1'b1, "rnd", lb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between N_REQ byte sources (push-button encoders, RX echo path, status reporters).
- Accepts a level request plus a data byte from each source.
- Launches one byte at a time into the transmitter and waits for its done flag.
- Returns a per-source acknowledge, and aborts with an error count if the transmitter hangs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- TIMEOUT_CYC, 200000, max clock cycles in WAIT_DONE before abort (>=2).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_Req  in  N_REQ  level request, bit k = requester k.
- i_Data  in  N_REQ*DATA_W  requester k byte at [k*DATA_W +: DATA_W].
- i_fReady  in  1  transmitter idle/ready.
- i_fDone  in  1  transmitter one-cycle done pulse.
- o_fStart  out  1  one-cycle launch pulse to transmitter.
- o_TxData  out  DATA_W  byte to transmitter, held stable from launch until release.
- o_Grant  out  N_REQ  one-hot, requester currently being served.
- o_Ack  out  N_REQ  one-cycle pulse, byte of requester k sent.
- o_fBusy  out  1  high in any state except IDLE.
- o_fErr  out  1  one-cycle pulse on timeout abort.
- o_ErrCnt  out  8  saturating timeout count (stops at 255).

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; o_fStart, o_TxData, o_Grant, o_Ack, o_fBusy, o_fErr, o_ErrCnt=0; timer=0; last-served pointer = N_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE:
  - If |i_Req and i_fReady at a clock edge: select the first set bit searching from (last+1) mod N_REQ upward with wrap.
  - Register o_Grant = one-hot(sel) and o_TxData = i_Data[sel]; go LAUNCH.
  - Otherwise stay. i_fReady=0 blocks launch.
- LAUNCH:
  - o_fStart=1 for exactly this one cycle. A request sampled at edge k gives o_fStart high during cycle k+1.
  - Clear timer; go WAIT_DONE.
- WAIT_DONE:
  - Timer increments each cycle.
  - On i_fDone=1: register o_Ack=o_Grant (one-cycle pulse in the next cycle); last=sel; go RELEASE.
  - Else if timer == TIMEOUT_CYC-1: o_fErr pulse next cycle; o_ErrCnt+1 (saturating); no ack; last=sel so a dead source cannot starve others; go RELEASE.
  - If done and timeout occur in the same cycle, done wins.
- RELEASE:
  - One cycle. o_Grant cleared; o_Ack/o_fErr pulse visible here; go IDLE.
  - o_TxData holds its last value until the next grant.
- i_fDone outside WAIT_DONE is ignored.
- o_TxData and o_Grant are frozen from grant through RELEASE. Changes to i_Data or a dropped i_Req during service do not affect the byte in flight, which is still sent and acked.
- Requesters must drop i_Req on their o_Ack pulse. A still-high request is treated as a new byte and is rescheduled only after the other pending requesters (round-robin fairness).
- Minimum cycles per byte: 4 + transmitter time. No back-to-back launch without passing RELEASE and IDLE.
- Timer width: clog2(TIMEOUT_CYC)+1 bits; no wrap within one wait.

Test Plan:
1. Reset, i_fReady=1, i_Req=4'b0010, req1 byte 0x41, model done 10 cycles after start -> o_fStart one cycle one clock after sample; o_TxData=0x41; o_Grant=0010; o_Ack=0010 one-cycle pulse; o_fBusy low after RELEASE.
2. i_Req=4'b1111 held, bytes 0x30..0x33, ack-driven model drops and re-raises requests -> launched byte order 0x30,0x31,0x32,0x33,0x30; each o_Ack in matching order.
3. i_Req=4'b0001 with i_fReady=0 for 20 cycles, then 1 -> no o_fStart during low ready; start exactly one cycle after ready is sampled high.
4. TIMEOUT_CYC=8, grant req2, never pulse done -> o_fErr pulse after 8 WAIT cycles; o_ErrCnt=1; no o_Ack; pending req3 served next. 256 timeouts -> o_ErrCnt stays 255.
5. Assert i_Rst mid-WAIT_DONE with req2 granted -> all outputs 0 immediately without a clock edge. After release with i_Req=4'b0101 -> requester 0 served first.
6. During WAIT_DONE, change i_Data of the granted requester from 0x55 to 0xAA and drop its i_Req -> o_TxData stays 0x55; ack still issued on done.
